weights_serial_loader: RTL and testbench
========================================

// Module: weights_serial_loader
// PURPOSE
//   Upstream feeder for the weights RAM write stage. Deserializes an MSB-first
//   bit stream into bytes and drives the 8-bit shift_reg bus the RAM stage
//   samples every cycle. Keeps a slot counter in lockstep with the RAM stage's
//   address counter, so each byte is held stable for one full address slot.
//   Loads RAM_DEPTH bytes per start command.
// PARAMETERS
//   RAM_DEPTH     8  bytes loaded per start; must match the RAM stage
//   COUNTER_BITS  3  slot length = 2**COUNTER_BITS cycles; must match the RAM stage
//   ADDR_BITS     localparam = $clog2(RAM_DEPTH)
// PORTS
//   clk           in   1          single clock
//   rst           in   1          synchronous, active-high reset
//   start         in   1          one-cycle load request
//   serial_valid  in   1          serial bit valid
//   serial_data   in   1          serial bit, MSB of each byte first
//   serial_ready  out  1          loader accepts the bit this cycle
//   shift_reg     out  8          byte bus to the RAM stage
//   slot_addr     out  ADDR_BITS  mirror of the RAM stage write address
//   busy          out  1          high in LOAD
//   done          out  1          high in DONE
//   underrun      out  1          sticky: a slot boundary passed with no byte ready
// BEHAVIOUR
//   Reset values: state=IDLE. shift_reg, slot counter, slot_addr, bit_cnt,
//     pending_full, bytes_accepted, bytes_loaded = 0.
//     serial_ready, busy, done, underrun = 0. A partial byte is discarded.
//   Slot counter: free-runs from reset in every state and increments each cycle.
//     The cycle where it equals 2**COUNTER_BITS-1 is the "boundary".
//     At the boundary edge the counter wraps to 0 and slot_addr increments,
//     wrapping mod 2**ADDR_BITS. This is the same edge at which the RAM stage
//     advances its address.
//   FSM: IDLE -start-> LOAD; LOAD -(bytes_loaded==RAM_DEPTH)-> DONE; DONE -start-> LOAD.
//     start in LOAD is ignored. Taking start clears underrun, bytes_accepted
//     and bytes_loaded.
//   Handshake: a bit transfers when serial_valid && serial_ready.
//     serial_ready = LOAD && bytes_accepted<RAM_DEPTH && !(pending_full && bit_cnt==7).
//   Assembly: asm <= {asm[6:0],serial_data}; bit_cnt increments and wraps
//     from 7 to 0. When the 8th bit transfers, the full byte moves to pending,
//     pending_full<=1 and bytes_accepted increments.
//   Boundary edge in LOAD with pending_full:
//     shift_reg<=pending, bytes_loaded increments, pending_full clears.
//     If a byte completes in the same cycle, that new byte refills pending
//     (net pending_full=1).
//   Boundary edge in LOAD with no pending byte and bytes_loaded>0:
//     underrun<=1, shift_reg holds, bytes_loaded unchanged.
//     Before the first byte no underrun is flagged.
//   Latency: a byte completed in cycle t appears on shift_reg on the first
//     boundary edge after t, and is then stable for exactly 2**COUNTER_BITS cycles.
//   The transition to DONE occurs on the boundary edge that loads byte RAM_DEPTH.
//     shift_reg holds that byte in IDLE/DONE.
//   rst mid-operation forces all reset values. There is no partial-byte recovery.
// STRUCTURE
//   Package weights_loader_pkg holds:
//     typedef enum logic [1:0] {IDLE, LOAD, DONE} loader_state_e;
//     localparam int BYTE_BITS = 8.
//   One sub-module, serial_byte_assembler: shift register, bit_cnt, and the
//   byte_done pulse with its byte output. The slot counter, pending register
//   and FSM stay in this top module.
// TESTING (bench instantiates the RAM stage model downstream; both share clk/rst)
//   1 Reset, no start, 40 cycles
//     -> shift_reg=0, serial_ready=0, slot_addr steps 0,1,2,... every 8 cycles.
//   2 start, then stream bytes 0x01..0x08 back-to-back with serial_valid=1
//     -> each byte appears on consecutive boundaries;
//     -> RAM model holds 0x01..0x08 at its 8 addresses;
//     -> done=1 after the 8th boundary, underrun=0.
//   3 start, send 0xA5, then idle 20 cycles before sending 0x3C
//     -> underrun=1 at the next boundary, shift_reg holds 0xA5,
//        then 0x3C loads at a later boundary.
//   4 Pending holds 0x11 and 7 bits of 0x22 are shifted in
//     -> serial_ready=0 until the boundary, then 1 the following cycle.
//   5 rst after 3 bits of a byte
//     -> all outputs return to reset values; a fresh start with 0xFF
//        loads 0xFF cleanly.
//   6 start pulsed during LOAD -> no effect;
//     start in DONE with underrun=1 -> underrun=0, busy=1, done=0.

Source files
------------

// File: rtl/weights_serial_loader_pkg.sv
// -----------------------------------------------------------------------------
// weights_loader_pkg
// Shared types and constants for the weights serial loader slice.
//   loader_state_e : loader FSM states (IDLE, LOAD, DONE)
//   BYTE_BITS      : width of one deserialized weight byte
//   BIT_CNT_BITS   : width of the in-byte bit counter
// -----------------------------------------------------------------------------
package weights_loader_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } loader_state_e;

    localparam int BYTE_BITS    = 8;
    localparam int BIT_CNT_BITS = $clog2(BYTE_BITS);

endpackage

// File: rtl/weights_serial_loader_if.sv
// -----------------------------------------------------------------------------
// weights_serial_loader_if
// Bundles the loader's command, serial handshake and RAM-stage bus signals.
//   start        : one-cycle load request          (master -> slave)
//   serial_valid : serial bit valid                (master -> slave)
//   serial_data  : serial bit, MSB first           (master -> slave)
//   serial_ready : loader accepts the bit          (slave -> master)
//   shift_reg    : byte bus sampled by RAM stage   (slave -> master)
//   slot_addr    : mirror of RAM stage address     (slave -> master)
//   busy / done  : FSM in LOAD / DONE              (slave -> master)
//   underrun     : sticky slot-without-byte flag   (slave -> master)
// -----------------------------------------------------------------------------
interface weights_serial_loader_if #(
    parameter int ADDR_BITS = 3
);
    import weights_loader_pkg::*;

    logic                 start;
    logic                 serial_valid;
    logic                 serial_data;
    logic                 serial_ready;
    logic [BYTE_BITS-1:0] shift_reg;
    logic [ADDR_BITS-1:0] slot_addr;
    logic                 busy;
    logic                 done;
    logic                 underrun;

    modport master (
        output start, serial_valid, serial_data,
        input  serial_ready, shift_reg, slot_addr, busy, done, underrun
    );

    modport slave (
        input  start, serial_valid, serial_data,
        output serial_ready, shift_reg, slot_addr, busy, done, underrun
    );

endinterface

// File: rtl/weights_serial_loader_assembler.sv
// -----------------------------------------------------------------------------
// serial_byte_assembler
// MSB-first serial-to-parallel shifter with an in-byte bit counter.
//   clk, rst  : clock, synchronous active-high reset (discards partial byte)
//   shift_en  : a bit transfers this cycle
//   bit_in    : the transferring bit
//   bit_cnt   : number of bits already held for the current byte
//   byte_done : the 8th bit of a byte transfers this cycle
//   byte_out  : the completed byte, valid while byte_done is high
// -----------------------------------------------------------------------------
module serial_byte_assembler
    import weights_loader_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    shift_en,
    input  logic                    bit_in,
    output logic [BIT_CNT_BITS-1:0] bit_cnt,
    output logic                    byte_done,
    output logic [BYTE_BITS-1:0]    byte_out
);

    localparam logic [BIT_CNT_BITS-1:0] BIT_LAST = {BIT_CNT_BITS{1'b1}};
    localparam logic [BIT_CNT_BITS-1:0] BIT_ONE  = BIT_CNT_BITS'(1);

    // Only the seven most recent bits need storing: the eighth is taken
    // straight from bit_in when the byte completes.
    logic [BYTE_BITS-2:0]    asm_r;
    logic [BIT_CNT_BITS-1:0] bit_cnt_r;

    // Shift in accepted bits; the counter wraps from 7 to 0 by width.
    always_ff @(posedge clk) begin
        if (rst) begin
            asm_r     <= {(BYTE_BITS-1){1'b0}};
            bit_cnt_r <= {BIT_CNT_BITS{1'b0}};
        end else if (shift_en) begin
            asm_r     <= {asm_r[BYTE_BITS-3:0], bit_in};
            bit_cnt_r <= bit_cnt_r + BIT_ONE;
        end else begin
            asm_r     <= asm_r;
            bit_cnt_r <= bit_cnt_r;
        end
    end

    assign bit_cnt   = bit_cnt_r;
    assign byte_done = shift_en && (bit_cnt_r == BIT_LAST);
    assign byte_out  = {asm_r, bit_in};

endmodule

// File: rtl/weights_serial_loader.sv
// -----------------------------------------------------------------------------
// weights_serial_loader
// Feeds the weights RAM write stage: deserializes an MSB-first bit stream,
// buffers one completed byte, and presents bytes on shift_reg aligned to
// slots of 2**COUNTER_BITS cycles that track the RAM stage address counter.
// Loads RAM_DEPTH bytes per start.
//   clk  : single clock
//   rst  : synchronous active-high reset
//   bus  : weights_serial_loader_if.slave (start, serial handshake,
//          shift_reg, slot_addr, busy, done, underrun)
// -----------------------------------------------------------------------------
module weights_serial_loader
    import weights_loader_pkg::*;
#(
    parameter int RAM_DEPTH    = 8,
    parameter int COUNTER_BITS = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    weights_serial_loader_if.slave  bus
);

    localparam int ADDR_BITS = $clog2(RAM_DEPTH);
    localparam int CNT_BITS  = $clog2(RAM_DEPTH + 1);

    localparam logic [COUNTER_BITS-1:0] SLOT_LAST = {COUNTER_BITS{1'b1}};
    localparam logic [COUNTER_BITS-1:0] SLOT_ONE  = COUNTER_BITS'(1);
    localparam logic [ADDR_BITS-1:0]    ADDR_ONE  = ADDR_BITS'(1);
    localparam logic [CNT_BITS-1:0]     DEPTH_CNT = CNT_BITS'(RAM_DEPTH);
    localparam logic [CNT_BITS-1:0]     CNT_ONE   = CNT_BITS'(1);
    localparam logic [CNT_BITS-1:0]     CNT_ZERO  = {CNT_BITS{1'b0}};
    localparam logic [BIT_CNT_BITS-1:0] BIT_LAST  = {BIT_CNT_BITS{1'b1}};

    loader_state_e           state_r;
    logic [COUNTER_BITS-1:0] slot_cnt_r;
    logic [ADDR_BITS-1:0]    slot_addr_r;
    logic [BYTE_BITS-1:0]    shift_reg_r;
    logic [BYTE_BITS-1:0]    pending_r;
    logic                    pending_full_r;
    logic [CNT_BITS-1:0]     bytes_accepted_r;
    logic [CNT_BITS-1:0]     bytes_loaded_r;
    logic                    busy_r;
    logic                    done_r;
    logic                    underrun_r;

    logic                    boundary_s;
    logic                    ready_s;
    logic                    xfer_s;
    logic [BIT_CNT_BITS-1:0] bit_cnt_s;
    logic                    byte_done_s;
    logic [BYTE_BITS-1:0]    byte_s;

    assign boundary_s = (slot_cnt_r == SLOT_LAST);
    assign xfer_s     = bus.serial_valid && ready_s;

    serial_byte_assembler u_asm (
        .clk       (clk),
        .rst       (rst),
        .shift_en  (xfer_s),
        .bit_in    (bus.serial_data),
        .bit_cnt   (bit_cnt_s),
        .byte_done (byte_done_s),
        .byte_out  (byte_s)
    );

    // Ready is a pure decode of registered state. The last bit of a byte is
    // held off while pending is still occupied, so a completed byte never
    // overwrites one the RAM stage has not yet received.
    always_comb begin
        ready_s = 1'b0;
        if ((state_r == LOAD) && (bytes_accepted_r < DEPTH_CNT) &&
            !(pending_full_r && (bit_cnt_s == BIT_LAST))) begin
            ready_s = 1'b1;
        end else begin
            ready_s = 1'b0;
        end
    end

    // Free-running slot counter and address mirror, running in every state
    // so they stay in lockstep with the RAM stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            slot_cnt_r  <= {COUNTER_BITS{1'b0}};
            slot_addr_r <= {ADDR_BITS{1'b0}};
        end else begin
            slot_cnt_r <= slot_cnt_r + SLOT_ONE;
            if (boundary_s) begin
                slot_addr_r <= slot_addr_r + ADDR_ONE;
            end else begin
                slot_addr_r <= slot_addr_r;
            end
        end
    end

    // Loader FSM with pending buffer, byte counters and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r          <= IDLE;
            shift_reg_r      <= {BYTE_BITS{1'b0}};
            pending_r        <= {BYTE_BITS{1'b0}};
            pending_full_r   <= 1'b0;
            bytes_accepted_r <= CNT_ZERO;
            bytes_loaded_r   <= CNT_ZERO;
            busy_r           <= 1'b0;
            done_r           <= 1'b0;
            underrun_r       <= 1'b0;
        end else begin
            case (state_r)
                IDLE, DONE: begin
                    if (bus.start) begin
                        state_r          <= LOAD;
                        busy_r           <= 1'b1;
                        done_r           <= 1'b0;
                        underrun_r       <= 1'b0;
                        bytes_accepted_r <= CNT_ZERO;
                        bytes_loaded_r   <= CNT_ZERO;
                    end else begin
                        state_r <= state_r;
                    end
                end
                LOAD: begin
                    if (byte_done_s) begin
                        pending_r        <= byte_s;
                        bytes_accepted_r <= bytes_accepted_r + CNT_ONE;
                    end else begin
                        pending_r <= pending_r;
                    end
                    if (boundary_s && pending_full_r) begin
                        // Hand the buffered byte to the RAM stage; a byte
                        // completing on this edge refills pending.
                        shift_reg_r    <= pending_r;
                        bytes_loaded_r <= bytes_loaded_r + CNT_ONE;
                        pending_full_r <= byte_done_s;
                        if (bytes_loaded_r == (DEPTH_CNT - CNT_ONE)) begin
                            state_r <= DONE;
                            busy_r  <= 1'b0;
                            done_r  <= 1'b1;
                        end else begin
                            state_r <= LOAD;
                        end
                    end else begin
                        if (byte_done_s) begin
                            pending_full_r <= 1'b1;
                        end else begin
                            pending_full_r <= pending_full_r;
                        end
                        // An empty slot only counts as an underrun once the
                        // stream has started delivering bytes.
                        if (boundary_s && (bytes_loaded_r != CNT_ZERO)) begin
                            underrun_r <= 1'b1;
                        end else begin
                            underrun_r <= underrun_r;
                        end
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.serial_ready = ready_s;
    assign bus.shift_reg    = shift_reg_r;
    assign bus.slot_addr    = slot_addr_r;
    assign bus.busy         = busy_r;
    assign bus.done         = done_r;
    assign bus.underrun     = underrun_r;

endmodule

// File: tb/tb_weights_serial_loader.sv
// -----------------------------------------------------------------------------
// tb_weights_serial_loader
// Directed bench for weights_serial_loader with a downstream RAM stage model.
// Stimulus pushes each fully sent byte into a queue; an independent monitor
// pops an entry whenever shift_reg changes and compares.
// -----------------------------------------------------------------------------
module tb_weights_serial_loader;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    weights_serial_loader_if #(.ADDR_BITS(3)) bus ();

    weights_serial_loader #(
        .RAM_DEPTH    (8),
        .COUNTER_BITS (3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_q[$];
    bit         consec_mode = 1'b0;

    // RAM stage model: own address counter, writes the slot's byte on the
    // last cycle of each slot while loading plus the final slot after done.
    logic [5:0] ram_cnt;
    logic [7:0] ram_mem [8];
    logic       done_wr;
    wire  [2:0] ram_addr = ram_cnt[5:3];
    wire        ram_bnd  = (ram_cnt[2:0] == 3'd7);

    always @(posedge clk) begin
        if (rst) begin
            ram_cnt <= 6'd0;
            done_wr <= 1'b0;
        end else begin
            ram_cnt <= ram_cnt + 6'd1;
            if (ram_bnd && (bus.busy || (bus.done && !done_wr)))
                ram_mem[ram_addr] <= bus.shift_reg;
            if (bus.busy)
                done_wr <= 1'b0;
            else if (bus.done && ram_bnd)
                done_wr <= 1'b1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: lockstep address check and scoreboard pop on every load.
    initial begin : monitor
        logic [7:0] prev_shift;
        logic [2:0] prev_addr;
        logic [2:0] last_load_addr;
        logic [2:0] next_addr;
        bit         have_load;
        prev_shift = 8'h00;
        prev_addr  = 3'd0;
        last_load_addr = 3'd0;
        have_load  = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_shift = 8'h00;
                prev_addr  = 3'd0;
                have_load  = 1'b0;
            end else begin
                chk("slot_addr_lockstep", bus.slot_addr, ram_addr);
                if (bus.shift_reg !== prev_shift) begin
                    chk("load_on_slot_edge", bus.slot_addr != prev_addr, 32'd1);
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_load: got %0h expected no load", bus.shift_reg);
                    end else begin
                        chk("shift_reg_byte", bus.shift_reg, exp_q.pop_front());
                    end
                    if (consec_mode && have_load) begin
                        next_addr = last_load_addr + 3'd1;
                        chk("consecutive_slot", bus.slot_addr, next_addr);
                    end
                    have_load      = 1'b1;
                    last_load_addr = bus.slot_addr;
                end
                prev_shift = bus.shift_reg;
                prev_addr  = bus.slot_addr;
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation time limit");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Present one bit and hold it until the loader accepts it.
    task automatic send_bit(input logic b);
        int n;
        n = 0;
        bus.serial_data  = b;
        bus.serial_valid = 1'b1;
        @(negedge clk);
        while (!bus.serial_ready && n < 64) begin
            @(negedge clk);
            n++;
        end
        if (!bus.serial_ready) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: got 0 expected 1 within 64 cycles");
        end
        cyc();
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) send_bit(v[i]);
        exp_q.push_back(v);
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        cyc();
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input int max);
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.done && n < max) begin
            @(negedge clk);
            n++;
        end
        chk("done_reached", bus.done, 32'd1);
    endtask

    initial begin : stimulus
        logic [2:0] a8;
        logic [2:0] idx;
        logic [7:0] b22;
        int n;
        bus.start        = 1'b0;
        bus.serial_valid = 1'b0;
        bus.serial_data  = 1'b0;

        // 1: reset, idle slots keep stepping the address
        rst = 1'b1;
        repeat (3) cyc();
        rst = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            chk("idle_shift_reg", bus.shift_reg, 32'h0);
            chk("idle_ready", bus.serial_ready, 32'd0);
            chk("idle_slot_addr", bus.slot_addr, (i / 8) % 8);
            if (i == 0) begin
                chk("idle_busy", bus.busy, 32'd0);
                chk("idle_done", bus.done, 32'd0);
                chk("idle_underrun", bus.underrun, 32'd0);
            end
            cyc();
        end

        // 2: full load of 0x01..0x08 back-to-back
        consec_mode = 1'b1;
        pulse_start();
        for (int v = 1; v <= 8; v++) send_byte(8'(v));
        bus.serial_valid = 1'b0;
        wait_done(200);
        chk("t2_busy", bus.busy, 32'd0);
        chk("t2_underrun", bus.underrun, 32'd0);
        chk("t2_last_byte", bus.shift_reg, 32'h08);
        a8 = bus.slot_addr;
        repeat (10) cyc();
        for (int i = 0; i < 8; i++) begin
            idx = a8 - 3'd7 + 3'(i);
            chk("t2_ram_content", ram_mem[idx], i + 1);
        end
        consec_mode = 1'b0;

        // 3: starved slot raises underrun, byte is held
        pulse_start();
        @(negedge clk);
        chk("t3_busy", bus.busy, 32'd1);
        chk("t3_done", bus.done, 32'd0);
        cyc();
        send_byte(8'hA5);
        bus.serial_valid = 1'b0;
        repeat (20) cyc();
        @(negedge clk);
        chk("t3_underrun", bus.underrun, 32'd1);
        chk("t3_hold", bus.shift_reg, 32'hA5);
        cyc();
        send_byte(8'h3C);
        bus.serial_valid = 1'b0;
        repeat (16) cyc();
        @(negedge clk);
        chk("t3_underrun_sticky", bus.underrun, 32'd1);
        cyc();

        // 4: pending full and 7 bits held -> ready low on the boundary cycle
        n = 0;
        while (ram_cnt[2:0] != 3'd0 && n < 16) begin
            cyc();
            n++;
        end
        send_byte(8'h11);
        b22 = 8'h22;
        for (int i = 7; i >= 1; i--) send_bit(b22[i]);
        bus.serial_data  = b22[0];
        bus.serial_valid = 1'b1;
        @(negedge clk);
        chk("t4_ready_blocked", bus.serial_ready, 32'd0);
        chk("t4_block_phase", ram_cnt[2:0], 32'd7);
        cyc();
        @(negedge clk);
        chk("t4_ready_after", bus.serial_ready, 32'd1);
        cyc();
        exp_q.push_back(b22);
        bus.serial_valid = 1'b0;
        repeat (20) cyc();

        // 5: reset mid-byte discards the partial byte
        for (int i = 0; i < 3; i++) send_bit(1'b0);
        bus.serial_valid = 1'b0;
        rst = 1'b1;
        cyc();
        @(negedge clk);
        chk("t5_shift_reg", bus.shift_reg, 32'h0);
        chk("t5_slot_addr", bus.slot_addr, 32'd0);
        chk("t5_ready", bus.serial_ready, 32'd0);
        chk("t5_busy", bus.busy, 32'd0);
        chk("t5_done", bus.done, 32'd0);
        chk("t5_underrun", bus.underrun, 32'd0);
        cyc();
        rst = 1'b0;
        pulse_start();
        send_byte(8'hFF);
        bus.serial_valid = 1'b0;
        repeat (24) cyc();

        // 6: start ignored in LOAD, honoured in DONE
        @(negedge clk);
        chk("t6_underrun_set", bus.underrun, 32'd1);
        cyc();
        pulse_start();
        @(negedge clk);
        chk("t6_load_busy", bus.busy, 32'd1);
        chk("t6_load_underrun", bus.underrun, 32'd1);
        chk("t6_load_done", bus.done, 32'd0);
        cyc();
        for (int v = 2; v <= 8; v++) send_byte(8'(v));
        bus.serial_valid = 1'b0;
        wait_done(200);
        chk("t6_done_underrun", bus.underrun, 32'd1);
        cyc();
        pulse_start();
        @(negedge clk);
        chk("t6_restart_underrun", bus.underrun, 32'd0);
        chk("t6_restart_busy", bus.busy, 32'd1);
        chk("t6_restart_done", bus.done, 32'd0);
        cyc();

        chk("queue_empty", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
